// File: rtl/dadda_pkg.sv
// Shared definitions for the 8x8 Dadda multiplier datapath: product width,
// carry-propagate pipeline cut position and the product/row type.
package dadda_pkg;

    localparam int unsigned PROD_W    = 16;
    localparam int unsigned CPA_SPLIT = 8;

    typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/cpa_slice.sv
// Parametric-width ripple-carry adder slice with carry in and carry out.
module cpa_slice
    import dadda_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    always_comb begin
        logic c;
        c     = cin_i;
        sum_o = '0;
        for (int unsigned i = 0; i < W; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        cout_o = c;
    end

endmodule

// File: rtl/dadda_cpa_pipe.sv
// Two-stage pipelined carry-propagate adder for the reduced Dadda rows:
// low SPLIT bits summed in stage 1, upper bits plus carry in stage 2.
module dadda_cpa_pipe
    import dadda_pkg::*;
#(
    parameter int unsigned WIDTH = PROD_W,
    parameter int unsigned SPLIT = CPA_SPLIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_row0,
    input  logic [WIDTH-1:0] in_row1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_product,
    output logic             out_cout,
    output logic [1:0]       occupancy
);

    localparam int unsigned HI_W = WIDTH - SPLIT;

    logic              s1_v_q,    s1_v_d;
    logic [SPLIT:0]    s1_lo_q,   s1_lo_d;
    logic [HI_W-1:0]   s1_hi0_q,  s1_hi0_d;
    logic [HI_W-1:0]   s1_hi1_q,  s1_hi1_d;
    logic              s2_v_q,    s2_v_d;
    logic [WIDTH-1:0]  s2_prod_q, s2_prod_d;
    logic              s2_cout_q, s2_cout_d;

    logic              s1_en, s2_en, accept;
    logic [SPLIT-1:0]  lo_sum;
    logic              lo_cout;
    logic [HI_W-1:0]   hi_sum;
    logic              hi_cout;

    cpa_slice #(.W(SPLIT)) u_lo (
        .a_i    (in_row0[SPLIT-1:0]),
        .b_i    (in_row1[SPLIT-1:0]),
        .cin_i  (1'b0),
        .sum_o  (lo_sum),
        .cout_o (lo_cout)
    );

    cpa_slice #(.W(HI_W)) u_hi (
        .a_i    (s1_hi0_q),
        .b_i    (s1_hi1_q),
        .cin_i  (s1_lo_q[SPLIT]),
        .sum_o  (hi_sum),
        .cout_o (hi_cout)
    );

    // in_ready is combinational from out_ready so a full pipe can still
    // consume, advance and accept on the same edge without a bubble.
    always_comb begin
        s2_en  = !s2_v_q || out_ready;
        s1_en  = !s1_v_q || s2_en;
        accept = in_valid && s1_en;
    end

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_lo_d   = s1_lo_q;
        s1_hi0_d  = s1_hi0_q;
        s1_hi1_d  = s1_hi1_q;
        s2_v_d    = s2_v_q;
        s2_prod_d = s2_prod_q;
        s2_cout_d = s2_cout_q;

        if (s1_en) begin
            s1_v_d = accept;
            if (accept) begin
                s1_lo_d  = {lo_cout, lo_sum};
                s1_hi0_d = in_row0[WIDTH-1:SPLIT];
                s1_hi1_d = in_row1[WIDTH-1:SPLIT];
            end
        end

        if (s2_en) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_prod_d = {hi_sum, s1_lo_q[SPLIT-1:0]};
                s2_cout_d = hi_cout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_lo_q   <= '0;
            s1_hi0_q  <= '0;
            s1_hi1_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_prod_q <= '0;
            s2_cout_q <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_lo_q   <= s1_lo_d;
            s1_hi0_q  <= s1_hi0_d;
            s1_hi1_q  <= s1_hi1_d;
            s2_v_q    <= s2_v_d;
            s2_prod_q <= s2_prod_d;
            s2_cout_q <= s2_cout_d;
        end
    end

    assign in_ready    = s1_en;
    assign out_valid   = s2_v_q;
    assign out_product = s2_prod_q;
    assign out_cout    = s2_cout_q;
    assign occupancy   = {1'b0, s1_v_q} + {1'b0, s2_v_q};

endmodule

// File: tb/tb_dadda_cpa_pipe.sv
// Bench for dadda_cpa_pipe: directed vector table, stall/throughput/reset
// sequences, and a randomized run scored against a queue-based sum model.
module tb_dadda_cpa_pipe;
    import dadda_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    prod_t       in_row0;
    prod_t       in_row1;
    logic        out_valid;
    logic        out_ready;
    prod_t       out_product;
    logic        out_cout;
    logic [1:0]  occupancy;

    always #5 clk = ~clk;

    dadda_cpa_pipe #(.WIDTH(PROD_W), .SPLIT(CPA_SPLIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row0     (in_row0),
        .in_row1     (in_row1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_cout    (out_cout),
        .occupancy   (occupancy)
    );

    int tests = 0;
    int fails = 0;
    int n_out = 0;
    bit mon_en = 1'b0;
    logic [16:0] exp_q[$];

    typedef struct {
        logic [15:0] r0;
        logic [15:0] r1;
        logic [15:0] prod;
        logic        cout;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Model: items in flight are exactly the queue contents; the head is
    // the next product the consumer must see.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("mon_occupancy", 32'(occupancy), 32'(exp_q.size()));
            check("mon_in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
            if (exp_q.size() == 0) check("mon_empty_valid", 32'(out_valid), 0);
            if (exp_q.size() == 2) check("mon_full_valid", 32'(out_valid), 1);
            if (out_valid && exp_q.size() != 0) begin
                check("mon_product", 32'(out_product), 32'(exp_q[0][15:0]));
                check("mon_cout", 32'(out_cout), 32'(exp_q[0][16]));
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                n_out++;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_add(in_row0, in_row1));
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_row0  = a;
        in_row1  = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("idle_drain", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base, cnt, first, last;

        vecs[0] = '{16'hFE00, 16'h0001, 16'hFE01, 1'b0};
        vecs[1] = '{16'h00FF, 16'h0001, 16'h0100, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0};
        vecs[3] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{16'h0F0F, 16'h00F1, 16'h1000, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
        vecs[7] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
        vecs[8] = '{16'h1234, 16'h0001, 16'h1235, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_row0   = '0;
        in_row1   = '0;
        out_ready = 1'b0;
        #3;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_product", 32'(out_product), 0);
        check("rst_cout", 32'(out_cout), 0);
        check("rst_occupancy", 32'(occupancy), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed vectors, one isolated pulse each.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_row0  = vecs[i].r0;
            in_row1  = vecs[i].r1;
            @(negedge clk);
            check("tbl_in_ready", 32'(in_ready), 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            check("tbl_s1_occ", 32'(occupancy), 1);
            check("tbl_s1_valid", 32'(out_valid), 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("tbl_valid", 32'(out_valid), 1);
            check("tbl_product", 32'(out_product), 32'(vecs[i].prod));
            check("tbl_cout", 32'(out_cout), 32'(vecs[i].cout));
            @(posedge clk); #1;
            @(negedge clk);
            check("tbl_empty_occ", 32'(occupancy), 0);
            @(posedge clk); #1;
        end

        // Backpressure: two accepts fill the pipe, third is held off.
        base      = n_out;
        out_ready = 1'b0;
        in_valid  = 1'b1; in_row0 = 16'h0001; in_row1 = 16'h0000;
        @(negedge clk);
        check("bp_ready1", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_row0 = 16'h0000; in_row1 = 16'h0002;
        @(negedge clk);
        check("bp_ready2", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_row0 = 16'h0001; in_row1 = 16'h0002;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_low", 32'(in_ready), 0);
            check("bp_occ", 32'(occupancy), 2);
            check("bp_stable", 32'(out_product), 32'h0001);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(16'h0001, 16'h0002);
        send(16'h0003, 16'h0001);
        wait_idle();
        check("bp_delivered", 32'(n_out - base), 4);

        // Throughput: 16 back-to-back items, no bubbles.
        cnt = 0; first = -1; last = -1;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) begin
                in_valid = 1'b1;
                in_row0  = prod_t'($urandom);
                in_row1  = prod_t'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 16) check("tp_in_ready", 32'(in_ready), 1);
            if (out_valid) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
            @(posedge clk); #1;
        end
        check("tp_count", 32'(cnt), 16);
        check("tp_span", 32'(last - first), 15);
        check("tp_first", 32'(first), 2);

        // Reset while full: everything discarded at once.
        out_ready = 1'b0;
        send(16'h0011, 16'h0000);
        send(16'h0022, 16'h0000);
        @(negedge clk);
        check("rm_full", 32'(occupancy), 2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rm_valid", 32'(out_valid), 0);
        check("rm_occ", 32'(occupancy), 0);
        check("rm_product", 32'(out_product), 0);
        check("rm_cout", 32'(out_cout), 0);
        check("rm_in_ready", 32'(in_ready), 1);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1; in_row0 = 16'h1234; in_row1 = 16'h0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rm_no_stale", 32'(out_valid), 0);
        check("rm_occ1", 32'(occupancy), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rm_new_valid", 32'(out_valid), 1);
        check("rm_new_product", 32'(out_product), 32'h1235);
        @(posedge clk); #1;

        // Randomized traffic with random backpressure.
        base = n_out;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_row0   = prod_t'($urandom);
            in_row1   = prod_t'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        check("rand_progress", 32'(n_out - base > 100), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
